// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame defaults, baud-select codes.
package uart_pkg;

   // Frame format defaults
   localparam int unsigned DATA_BITS_DEF   = 8;
   localparam int unsigned OVERSAMPLE_DEF  = 16;
   localparam bit          PARITY_EVEN_DEF = 1'b1;

   // Receiver FSM state encoding
   localparam int unsigned STATE_W   = 3;
   localparam logic [2:0]  ST_IDLE   = 3'd0;
   localparam logic [2:0]  ST_START  = 3'd1;
   localparam logic [2:0]  ST_DATA   = 3'd2;
   localparam logic [2:0]  ST_PARITY = 3'd3;
   localparam logic [2:0]  ST_STOP   = 3'd4;

   // Baud-select codes shared with the baud controllers and the transmitter
   localparam int unsigned BAUD_SEL_W  = 3;
   localparam logic [2:0]  BAUD_300    = 3'd0;
   localparam logic [2:0]  BAUD_1200   = 3'd1;
   localparam logic [2:0]  BAUD_4800   = 3'd2;
   localparam logic [2:0]  BAUD_9600   = 3'd3;
   localparam logic [2:0]  BAUD_19200  = 3'd4;
   localparam logic [2:0]  BAUD_38400  = 3'd5;
   localparam logic [2:0]  BAUD_57600  = 3'd6;
   localparam logic [2:0]  BAUD_115200 = 3'd7;

   // Two-out-of-three vote used for bit decisions
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RxD synchronizer, oversampling tick counter and mid-bit 3-sample majority vote.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_en_i,
   input  logic rxd_i,
   input  logic cnt_clr_i,
   output logic rxd_s_o,
   output logic bit_value_c_o,
   output logic bit_decide_c_o,
   output logic bit_end_c_o
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned MID   = OVERSAMPLE / 2;

   localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(MID + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_early_q, s_early_d;
   logic             s_mid_q, s_mid_d;

   // Counter advance and capture of the first two votes
   always_comb begin
      cnt_d     = cnt_q;
      s_early_d = s_early_q;
      s_mid_d   = s_mid_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (sample_en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         if (cnt_q == CNT_EARLY) s_early_d = sync2_q;
         if (cnt_q == CNT_MID)   s_mid_d   = sync2_q;
      end
   end

   // Synchronizer, counter and vote registers; line idles high out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= '0;
         s_early_q <= 1'b1;
         s_mid_q   <= 1'b1;
      end else begin
         sync1_q   <= rxd_i;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         s_early_q <= s_early_d;
         s_mid_q   <= s_mid_d;
      end
   end

   assign rxd_s_o        = sync2_q;
   assign bit_value_c_o  = majority3(s_early_q, s_mid_q, sync2_q);
   assign bit_decide_c_o = sample_en_i && !cnt_clr_i && (cnt_q == CNT_DECIDE);
   assign bit_end_c_o    = sample_en_i && !cnt_clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receive datapath: frames start/data/parity/stop off the oversampled line.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
   parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter bit          PARITY_EVEN = PARITY_EVEN_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_ENABLE,
   input  logic                 Rx_EN,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] Rx_DATA,
   output logic                 Rx_VALID,
   output logic                 Rx_PERROR,
   output logic                 Rx_FERROR,
   output logic                 Rx_BUSY
);

   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic [STATE_W-1:0]   state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 par_q, par_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;
   logic                 hold_q, hold_d;

   logic                 rxd_s;
   logic                 bit_value_c;
   logic                 bit_decide_c;
   logic                 bit_end_c;
   logic                 cnt_clr_c;
   logic                 par_target_c;
   logic                 perr_c;

   // Counter is parked at zero while idle or disabled so a start detect begins at cnt=0
   assign cnt_clr_c = (state_q == ST_IDLE) || !Rx_EN;

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk            (clk),
      .reset          (reset),
      .sample_en_i    (sample_ENABLE),
      .rxd_i          (RxD),
      .cnt_clr_i      (cnt_clr_c),
      .rxd_s_o        (rxd_s),
      .bit_value_c_o  (bit_value_c),
      .bit_decide_c_o (bit_decide_c),
      .bit_end_c_o    (bit_end_c)
   );

   // XOR of data and parity bit the line should carry for the selected parity sense
   assign par_target_c = PARITY_EVEN ? 1'b0 : 1'b1;
   assign perr_c       = ((^shift_q) ^ par_q) ^ par_target_c;

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      data_d  = data_q;
      idx_d   = idx_q;
      par_d   = par_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      hold_d  = hold_q;

      // After a low stop bit the line must be seen high once before a new start
      if (sample_ENABLE && rxd_s) hold_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sample_ENABLE && !rxd_s && !hold_q) state_d = ST_START;
         end
         ST_START: begin
            if (bit_decide_c && bit_value_c) begin
               state_d = ST_IDLE;
            end else if (bit_end_c) begin
               state_d = ST_DATA;
               idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_decide_c) shift_d = DATA_BITS'({bit_value_c, shift_q} >> 1);
            if (bit_end_c) begin
               if (idx_q == IDX_LAST) state_d = ST_PARITY;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_PARITY: begin
            if (bit_decide_c) par_d   = bit_value_c;
            if (bit_end_c)    state_d = ST_STOP;
         end
         ST_STOP: begin
            // Leave half a bit early so a directly following start edge is caught
            if (bit_decide_c) begin
               state_d = ST_IDLE;
               data_d  = shift_q;
               perr_d  = perr_c;
               ferr_d  = !bit_value_c;
               valid_d = !perr_c && bit_value_c;
               hold_d  = !bit_value_c;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disable discards any partial frame without pulses
      if (!Rx_EN) begin
         state_d = ST_IDLE;
         data_d  = data_q;
         valid_d = 1'b0;
         perr_d  = 1'b0;
         ferr_d  = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         par_q   <= 1'b0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         par_q   <= par_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   assign Rx_DATA   = data_q;
   assign Rx_VALID  = valid_q;
   assign Rx_PERROR = perr_q;
   assign Rx_FERROR = ferr_q;
   assign Rx_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frame table, random frames vs. a frame-level model, corner sequences.
module tb_uart_receiver;

   localparam int unsigned BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clk

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_ENABLE;
   logic       Rx_EN;
   logic       RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID;
   logic       Rx_PERROR;
   logic       Rx_FERROR;
   logic       Rx_BUSY;

   logic [1:0] div_q = 2'd0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       perr;
      logic       ferr;
   } obs_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stp;
      int         gap_bits;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   obs_t obs[$];
   logic busy_seen = 1'b0;

   uart_receiver #(
      .DATA_BITS   (8),
      .OVERSAMPLE  (16),
      .PARITY_EVEN (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sample_ENABLE (sample_ENABLE),
      .Rx_EN         (Rx_EN),
      .RxD           (RxD),
      .Rx_DATA       (Rx_DATA),
      .Rx_VALID      (Rx_VALID),
      .Rx_PERROR     (Rx_PERROR),
      .Rx_FERROR     (Rx_FERROR),
      .Rx_BUSY       (Rx_BUSY)
   );

   always #5 clk = ~clk;

   // One tick every fourth clock
   always @(posedge clk) div_q <= div_q + 2'd1;
   assign sample_ENABLE = (div_q == 2'd0);

   // Record every clock carrying a result pulse; a wide pulse shows up as extra entries
   always @(negedge clk) begin
      if (Rx_VALID || Rx_PERROR || Rx_FERROR) begin
         obs_t o;
         o.data  = Rx_DATA;
         o.valid = Rx_VALID;
         o.perr  = Rx_PERROR;
         o.ferr  = Rx_FERROR;
         obs.push_back(o);
      end
      if (Rx_BUSY) busy_seen = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame-level reference: what the receiver should report for a frame put on the line
   function automatic obs_t model(input logic [7:0] d, input logic par, input logic stp);
      obs_t r;
      int   ones;
      ones    = $countones({d, par});
      r.data  = d;
      r.perr  = (ones % 2) != 0;      // even parity: data plus parity bit has an even count
      r.ferr  = (stp == 1'b0);
      r.valid = !r.perr && !r.ferr;
      return r;
   endfunction

   // abort_kind: 0 none, 1 drop Rx_EN mid bit, 2 pulse reset mid bit (abort_bit 0 = start bit)
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int abort_bit, input int abort_kind);
      logic [10:0] bits;
      bits = {stp, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         RxD = bits[i];
         for (int c = 0; c < BIT_CLKS; c++) begin
            @(negedge clk);
            if (abort_kind != 0 && i == abort_bit && c == BIT_CLKS / 2) begin
               if (abort_kind == 1) begin
                  chk("en_pre_busy", 32'(Rx_BUSY), 32'd1);
                  Rx_EN = 1'b0;
                  @(negedge clk);
                  chk("en_off_busy", 32'(Rx_BUSY), 32'd0);
                  chk("en_off_valid", 32'(Rx_VALID), 32'd0);
               end else begin
                  reset = 1'b1;
                  @(negedge clk);
                  reset = 1'b0;
                  chk("rst_mid_data", 32'(Rx_DATA), 32'd0);
                  chk("rst_mid_flags", {28'd0, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY}, 32'd0);
                  RxD = 1'b1;
                  return;
               end
            end
         end
      end
      RxD = 1'b1;
   endtask

   task automatic idle_bits(input int n);
      RxD = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic check_frame(input string name, input obs_t e);
      chk({name, "_count"}, 32'(obs.size()), 32'd1);
      if (obs.size() > 0) begin
         chk({name, "_data"},  32'(obs[0].data), 32'(e.data));
         chk({name, "_flags"}, {29'd0, obs[0].valid, obs[0].perr, obs[0].ferr},
                               {29'd0, e.valid, e.perr, e.ferr});
      end
      chk({name, "_hold"}, 32'(Rx_DATA), 32'(e.data));
      chk({name, "_busy"}, 32'(Rx_BUSY), 32'd0);
      obs.delete();
   endtask

   vec_t vecs[6];

   initial begin
      obs_t e;
      logic [7:0] rd;
      logic       rpar, rstp;
      int         rgap;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 2, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 2, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 2, 8'h3C, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h01, 1'b0, 1'b0, 2, 8'h01, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b0, 1'b1, 2, 8'hFF, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      Rx_EN = 1'b1;
      RxD   = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_data", 32'(Rx_DATA), 32'd0);
      chk("reset_flags", {28'd0, Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY}, 32'd0);
      reset = 1'b0;
      idle_bits(1);
      obs.delete();

      // Directed table (rows 4 and 5 are back-to-back with no idle gap)
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].par, vecs[i].stp, 0, 0);
         e.data  = vecs[i].exp_data;
         e.valid = vecs[i].exp_valid;
         e.perr  = vecs[i].exp_perr;
         e.ferr  = vecs[i].exp_ferr;
         check_frame($sformatf("vec%0d", i), e);
         if (vecs[i].gap_bits > 0) idle_bits(vecs[i].gap_bits);
      end

      // Glitch: short low pulse is a false start
      busy_seen = 1'b0;
      RxD = 1'b0;
      repeat (20) @(negedge clk);
      RxD = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_busy_rose", 32'(busy_seen), 32'd1);
      chk("glitch_busy_low", 32'(Rx_BUSY), 32'd0);
      chk("glitch_no_pulse", 32'(obs.size()), 32'd0);
      obs.delete();

      // Disable during data bit 3, then a clean frame after re-enable
      send_frame(8'hC6, 1'b0, 1'b1, 4, 1);
      idle_bits(2);
      chk("en_off_no_pulse", 32'(obs.size()), 32'd0);
      Rx_EN = 1'b1;
      idle_bits(1);
      obs.delete();
      send_frame(8'h5A, 1'b0, 1'b1, 0, 0);
      e = model(8'h5A, 1'b0, 1'b1);
      check_frame("reen_5a", e);
      idle_bits(1);

      // Reset in data bit 2, then a clean frame
      send_frame(8'hC3, 1'b0, 1'b1, 3, 2);
      idle_bits(2);
      chk("rst_no_pulse", 32'(obs.size()), 32'd0);
      obs.delete();
      send_frame(8'h81, 1'b0, 1'b1, 0, 0);
      e = model(8'h81, 1'b0, 1'b1);
      check_frame("post_rst_81", e);
      idle_bits(1);

      // Break: long low line yields a single framing error
      RxD = 1'b0;
      repeat (30 * BIT_CLKS) @(negedge clk);
      idle_bits(2);
      e.data = 8'h00; e.valid = 1'b0; e.perr = 1'b0; e.ferr = 1'b1;
      check_frame("break", e);
      send_frame(8'h3C, 1'b0, 1'b1, 0, 0);
      e = model(8'h3C, 1'b0, 1'b1);
      check_frame("post_break", e);
      idle_bits(1);

      // Random frames against the frame-level model
      for (int i = 0; i < 24; i++) begin
         rd   = 8'($urandom);
         rpar = ^rd;
         if ($urandom_range(0, 3) == 0) rpar = ~rpar;
         rstp = ($urandom_range(0, 3) != 0);
         rgap = rstp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         send_frame(rd, rpar, rstp, 0, 0);
         e = model(rd, rpar, rstp);
         check_frame($sformatf("rand%0d", i), e);
         if (rgap > 0) idle_bits(rgap);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
